wide_alu_seq: RTL and testbench

Multi-cycle 16-bit sequencer that executes a two-word (MSW:LSW) logic or shift operation as two chained 8-bit slice passes. The carry/shift bit leaving the first slice feeds the second slice. It sits between the control unit and the register file for double-width instructions. It presents a start/busy/done handshake and returns a 16-bit result, a final shift-out bit and a zero flag.

---
 rtl/wide_alu_seq.sv | 159 +++++++++++++++
 tb/tb_wide_alu_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_alu_seq.sv
// Purpose: 16-bit logic/shift sequencer run as two chained 8-bit slice passes (MSW:LSW); optional ROL/ROR behind macro WIDE_ALU_SEQ_ROTATE_EN.
// Latency: START accepted at edge E0, RESULT/SC_OUT/ZERO registered and DONE pulsed at E2; one operation every 3 cycles.
// Backpressure: none; START is sampled only in IDLE, and a START seen while BUSY is dropped, not queued.
module wide_alu_seq (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [2:0]  OP,
    input  logic [15:0] INPUTA,
    input  logic [15:0] INPUTB,
    input  logic        SC_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RESULT,
    output logic        SC_OUT,
    output logic        ZERO
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FIRST  = 2'd1;
    localparam logic [1:0] S_SECOND = 2'd2;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_LSH = 3'd1;
    localparam logic [2:0] OP_RSH = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
`ifdef WIDE_ALU_SEQ_ROTATE_EN
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;
`endif

    logic [1:0]  state;
    logic [2:0]  op_r;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic        sc_in_r;
    logic [7:0]  slice_r;
    logic        chain_r;

    logic [7:0]  first_slice;
    logic        first_chain;
    logic [15:0] final_result;
    logic        final_sc;

    // First pass: LSW for bitwise ops and left shifts, MSW for right shifts; also produce the chain bit.
    always_comb begin
        first_slice = 8'h00;
        first_chain = 1'b0;
        case (op_r)
            OP_AND: first_slice = a_r[7:0] & b_r[7:0];
            OP_XOR: first_slice = a_r[7:0] ^ b_r[7:0];
            OP_LSH: begin
                first_slice = {a_r[6:0], sc_in_r};
                first_chain = a_r[7];
            end
            OP_RSH: begin
                first_slice = {sc_in_r, a_r[15:9]};
                first_chain = a_r[8];
            end
`ifdef WIDE_ALU_SEQ_ROTATE_EN
            // Rotates wrap the far end of the word in place of SC_IN.
            OP_ROL: begin
                first_slice = {a_r[6:0], a_r[15]};
                first_chain = a_r[7];
            end
            OP_ROR: begin
                first_slice = {a_r[0], a_r[15:9]};
                first_chain = a_r[8];
            end
`endif
            default: begin
                first_slice = 8'h00;
                first_chain = 1'b0;
            end
        endcase
    end

    // Second pass: consume the chain bit and assemble the full word plus the final shift-out bit.
    always_comb begin
        final_result = 16'h0000;
        final_sc     = 1'b0;
        case (op_r)
            OP_AND: final_result = {a_r[15:8] & b_r[15:8], slice_r};
            OP_XOR: final_result = {a_r[15:8] ^ b_r[15:8], slice_r};
            OP_LSH: begin
                final_result = {a_r[14:8], chain_r, slice_r};
                final_sc     = a_r[15];
            end
            OP_RSH: begin
                final_result = {slice_r, chain_r, a_r[7:1]};
                final_sc     = a_r[0];
            end
`ifdef WIDE_ALU_SEQ_ROTATE_EN
            OP_ROL: begin
                final_result = {a_r[14:8], chain_r, slice_r};
                final_sc     = a_r[15];
            end
            OP_ROR: begin
                final_result = {slice_r, chain_r, a_r[7:1]};
                final_sc     = a_r[0];
            end
`endif
            default: begin
                final_result = 16'h0000;
                final_sc     = 1'b0;
            end
        endcase
    end

    // Sequencer: latch operands in IDLE, run the two slice passes, publish the result with a one-cycle DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            op_r    <= 3'd0;
            a_r     <= 16'h0000;
            b_r     <= 16'h0000;
            sc_in_r <= 1'b0;
            slice_r <= 8'h00;
            chain_r <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RESULT  <= 16'h0000;
            SC_OUT  <= 1'b0;
            ZERO    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        op_r    <= OP;
                        a_r     <= INPUTA;
                        b_r     <= INPUTB;
                        sc_in_r <= SC_IN;
                        BUSY    <= 1'b1;
                        state   <= S_FIRST;
                    end
                end
                S_FIRST: begin
                    slice_r <= first_slice;
                    chain_r <= first_chain;
                    state   <= S_SECOND;
                end
                S_SECOND: begin
                    RESULT <= final_result;
                    SC_OUT <= final_sc;
                    ZERO   <= (final_result == 16'h0000);
                    DONE   <= 1'b1;
                    BUSY   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_alu_seq.sv
module tb_wide_alu_seq;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [2:0]  OP;
    logic [15:0] INPUTA;
    logic [15:0] INPUTB;
    logic        SC_IN;
    logic        BUSY;
    logic        DONE;
    logic [15:0] RESULT;
    logic        SC_OUT;
    logic        ZERO;

    typedef struct packed {
        logic [15:0] res;
        logic        sc;
        logic        z;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        sc;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    wide_alu_seq dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .OP     (OP),
        .INPUTA (INPUTA),
        .INPUTB (INPUTB),
        .SC_IN  (SC_IN),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .SC_OUT (SC_OUT),
        .ZERO   (ZERO)
    );

    always #5 CLK = ~CLK;

    // Whole-word reference: shifts/rotates written directly on 16 bits.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic sc);
        exp_t e;
        e.res = 16'h0000;
        e.sc  = 1'b0;
        case (op)
            3'd0: e.res = a & b;
            3'd1: begin e.res = {a[14:0], sc}; e.sc = a[15]; end
            3'd2: begin e.res = {sc, a[15:1]}; e.sc = a[0]; end
            3'd3: e.res = a ^ b;
`ifdef WIDE_ALU_SEQ_ROTATE_EN
            3'd4: begin e.res = {a[14:0], a[15]}; e.sc = a[15]; end
            3'd5: begin e.res = {a[0], a[15:1]}; e.sc = a[0]; end
`endif
            default: begin e.res = 16'h0000; e.sc = 1'b0; end
        endcase
        e.z = (e.res == 16'h0000);
        return e;
    endfunction

    // Called at a negedge: present a request for one edge and record its expected result.
    task automatic launch(input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic sc);
        OP = op; INPUTA = a; INPUTB = b; SC_IN = sc; START = 1'b1;
        q.push_back(model(op, a, b, sc));
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Bounded wait for DONE, counted in negedges after the acceptance edge's negedge.
    task automatic wait_done(output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1; START = 1'b0; OP = 3'd0; INPUTA = 16'h0; INPUTB = 16'h0; SC_IN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
        checks++; if (DONE !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", DONE); end
        checks++; if (RESULT !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", RESULT); end
        checks++; if (SC_OUT !== 1'b0)     begin errors++; $display("FAIL reset_sc_out got %b want 0", SC_OUT); end
        checks++; if (ZERO !== 1'b0)       begin errors++; $display("FAIL reset_zero got %b want 0", ZERO); end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic_ops;
        vec_t v[9];
        exp_t e;
        int   lat;
        bit   seen;
        v[0] = '{3'd1, 16'h80FF, 16'h0000, 1'b1};  // LSH
        v[1] = '{3'd2, 16'h0101, 16'h0000, 1'b0};  // RSH
        v[2] = '{3'd3, 16'hA5A5, 16'hA5A5, 1'b0};  // XOR to zero
        v[3] = '{3'd4, 16'h8001, 16'h0000, 1'b0};  // ROL (no-op without macro)
        v[4] = '{3'd5, 16'h8001, 16'h0000, 1'b1};  // ROR (no-op without macro)
        v[5] = '{3'd6, 16'hFFFF, 16'hFFFF, 1'b1};  // no-op
        v[6] = '{3'd7, 16'h1234, 16'h5678, 1'b1};  // no-op
        v[7] = '{3'd0, 16'hFFFF, 16'h00FF, 1'b0};  // AND
        v[8] = '{3'd2, 16'h8000, 16'h0000, 1'b1};  // RSH with shift-in
        for (int i = 0; i < 9; i++) begin
            launch(v[i].op, v[i].a, v[i].b, v[i].sc);
            checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL op%0d_busy got %b want 1", i, BUSY); end
            wait_done(lat, seen);
            checks++; if (!seen || lat != 2) begin errors++; $display("FAIL op%0d_latency got %0d seen=%0d want 2", i, lat, seen); end
            e = q.pop_front();
            checks++; if (RESULT !== e.res) begin errors++; $display("FAIL op%0d_result got %h want %h", i, RESULT, e.res); end
            checks++; if (SC_OUT !== e.sc)  begin errors++; $display("FAIL op%0d_sc_out got %b want %b", i, SC_OUT, e.sc); end
            checks++; if (ZERO !== e.z)     begin errors++; $display("FAIL op%0d_zero got %b want %b", i, ZERO, e.z); end
            checks++; if (BUSY !== 1'b0)    begin errors++; $display("FAIL op%0d_busy_at_done got %b want 0", i, BUSY); end
            @(negedge CLK);
            checks++; if (DONE !== 1'b0)    begin errors++; $display("FAIL op%0d_done_pulse got %b want 0", i, DONE); end
        end
    endtask

    task automatic test_and_latch;
        exp_t e;
        int   lat;
        bit   seen;
        launch(3'd0, 16'hF0F0, 16'h3C3C, 1'b0);
        OP = 3'd3; INPUTA = 16'h0000; INPUTB = 16'hFFFF; SC_IN = 1'b1;
        wait_done(lat, seen);
        e = q.pop_front();
        checks++; if (!seen)            begin errors++; $display("FAIL latch_done got none want pulse"); end
        checks++; if (RESULT !== e.res) begin errors++; $display("FAIL latch_result got %h want %h", RESULT, e.res); end
        checks++; if (ZERO !== e.z)     begin errors++; $display("FAIL latch_zero got %b want %b", ZERO, e.z); end
        @(negedge CLK);
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        int   extra;
        launch(3'd0, 16'hFFFF, 16'h0F0F, 1'b0);
        START = 1'b1; OP = 3'd3; INPUTA = 16'h1234; INPUTB = 16'h4321; SC_IN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        START = 1'b0;
        e = q.pop_front();
        checks++; if (DONE !== 1'b1)    begin errors++; $display("FAIL busy_ign_done got %b want 1", DONE); end
        checks++; if (RESULT !== e.res) begin errors++; $display("FAIL busy_ign_result got %h want %h", RESULT, e.res); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1 || BUSY === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_ign_extra got %0d busy/done cycles want 0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals[4];
        exp_t e;
        int   dones;
        vals[0] = 16'h8001; vals[1] = 16'h1234; vals[2] = 16'hFFFF; vals[3] = 16'h0000;
        OP = 3'd1; INPUTB = 16'h0000; SC_IN = 1'b1; INPUTA = vals[0]; START = 1'b1;
        q.push_back(model(3'd1, vals[0], 16'h0000, 1'b1));
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                checks++; if (i != 2 + 3 * dones) begin errors++; $display("FAIL b2b_spacing got cycle %0d want %0d", i, 2 + 3 * dones); end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    checks++; if (RESULT !== e.res) begin errors++; $display("FAIL b2b_result%0d got %h want %h", dones, RESULT, e.res); end
                    checks++; if (SC_OUT !== e.sc)  begin errors++; $display("FAIL b2b_sc_out%0d got %b want %b", dones, SC_OUT, e.sc); end
                end
                dones++;
            end
            if (i % 3 == 0 && i < 9) begin
                INPUTA = vals[i / 3 + 1];
                q.push_back(model(3'd1, vals[i / 3 + 1], 16'h0000, 1'b1));
            end
            if (i == 11) START = 1'b0;
        end
        checks++; if (dones != 4)    begin errors++; $display("FAIL b2b_count got %0d want 4", dones); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_queue got %0d left want 0", q.size()); end
        q.delete();
        @(negedge CLK);
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   lat;
        int   spurious;
        bit   seen;
        launch(3'd1, 16'hFFFF, 16'h0000, 1'b1);
        RESET = 1'b1;
        #1;
        checks++; if (BUSY !== 1'b0)       begin errors++; $display("FAIL rst_mid_busy got %b want 0", BUSY); end
        checks++; if (RESULT !== 16'h0000) begin errors++; $display("FAIL rst_mid_result got %h want 0000", RESULT); end
        checks++; if (SC_OUT !== 1'b0)     begin errors++; $display("FAIL rst_mid_sc_out got %b want 0", SC_OUT); end
        q.delete();
        @(negedge CLK);
        RESET = 1'b0;
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rst_mid_done got %0d pulses want 0", spurious); end
        launch(3'd3, 16'h1234, 16'h00FF, 1'b0);
        wait_done(lat, seen);
        e = q.pop_front();
        checks++; if (!seen || lat != 2) begin errors++; $display("FAIL rst_after_latency got %0d want 2", lat); end
        checks++; if (RESULT !== e.res)  begin errors++; $display("FAIL rst_after_result got %h want %h", RESULT, e.res); end
        @(negedge CLK);
    endtask

    task automatic test_random;
        exp_t e;
        int   lat;
        bit   seen;
        for (int i = 0; i < 20; i++) begin
            launch(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
            wait_done(lat, seen);
            e = q.pop_front();
            checks++; if (!seen)            begin errors++; $display("FAIL rnd%0d_done got none want pulse", i); end
            checks++; if (RESULT !== e.res) begin errors++; $display("FAIL rnd%0d_result got %h want %h", i, RESULT, e.res); end
            checks++; if (SC_OUT !== e.sc)  begin errors++; $display("FAIL rnd%0d_sc_out got %b want %b", i, SC_OUT, e.sc); end
            checks++; if (ZERO !== e.z)     begin errors++; $display("FAIL rnd%0d_zero got %b want %b", i, ZERO, e.z); end
            @(negedge CLK);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_ops();
        test_and_latch();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
